// File: rtl/seq_priority_encoder8_pkg.sv
// Shared types and helpers for the sequential 8-to-3 priority encoder.
// onehot_of is the exact inverse of the encoder's index mapping.
package enc_pkg;

   localparam int N  = 8;
   localparam int IW = 3;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   function automatic logic [N-1:0] onehot_of(input logic [IW-1:0] idx);
      logic [N-1:0] r;
      r      = '0;
      r[idx] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/seq_priority_encoder8_pick_bit8.sv
// Combinational find-first-set over an 8-bit vector, either direction.
// idx is 0 for an empty vector; single flags exactly one bit set.
module pick_bit8
   import enc_pkg::*;
(
   input  logic [N-1:0]  vec,
   input  logic          lsb_first,
   output logic [IW-1:0] idx,
   output logic          single
);

   always_comb begin
      idx = '0;
      if (lsb_first) begin
         // Scan downward so the lowest set bit wins.
         for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = IW'(i);
         end
      end
   end

   always_comb begin
      single = (vec != '0) && ((vec & (vec - N'(1))) == '0);
   end

endmodule

// File: rtl/seq_priority_encoder8.sv
// Sequential 8-to-3 priority encoder: captures a request vector and
// emits one binary index per output transfer, in priority order.
module seq_priority_encoder8
   import enc_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_vec,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [IW-1:0] out_idx,
   output logic          out_last,
   output logic          busy,
   output logic          zero_err
);

   state_e       state_q, state_d;
   logic [N-1:0] pending_q, pending_d;
   logic         zero_err_q, zero_err_d;

   logic [IW-1:0] pick_idx;
   logic          pick_single;

   pick_bit8 u_pick (
      .vec       (pending_q),
      .lsb_first (LSB_FIRST),
      .idx       (pick_idx),
      .single    (pick_single)
   );

   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      zero_err_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (in_vec != '0) begin
                  pending_d = in_vec;
                  state_d   = SCAN;
               end else begin
                  zero_err_d = 1'b1;
               end
            end
         end
         SCAN: begin
            if (out_ready) begin
               pending_d = pending_q & ~onehot_of(pick_idx);
               if (pick_single) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pending_q  <= '0;
         zero_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         zero_err_q <= zero_err_d;
      end
   end

   // pending_q is empty whenever IDLE, so idx/last read back as zero there.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == SCAN);
      busy      = (state_q == SCAN);
      out_idx   = pick_idx;
      out_last  = (state_q == SCAN) && pick_single;
      zero_err  = zero_err_q;
   end

endmodule
